// File: rtl/hdmi_pkg.sv
// Shared HDMI output-stage definitions: bus widths, pack bit layout and the
// constant reciprocal table builder used by the white-balance output stage.
package hdmi_pkg;

    localparam int unsigned PACK_W = 49;
    localparam int unsigned X_W    = 11;
    localparam int unsigned Y_W    = 10;
    localparam int unsigned TIM_W  = 3 + X_W + Y_W;

    localparam int unsigned PK_CLK   = 48;
    localparam int unsigned PK_HSYNC = 47;
    localparam int unsigned PK_VSYNC = 46;
    localparam int unsigned PK_DE    = 45;
    localparam int unsigned PK_R_LSB = 37;
    localparam int unsigned PK_G_LSB = 29;
    localparam int unsigned PK_B_LSB = 21;
    localparam int unsigned PK_X_LSB = 10;
    localparam int unsigned PK_Y_LSB = 0;

    typedef struct packed {
        logic           hsync;
        logic           vsync;
        logic           de;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } timing_t;

    typedef logic [255:0][31:0] recip_rom_t;

    // Averages of 0 and 1 saturate rather than divide by zero or overflow.
    function automatic logic [31:0] recip_of(input int unsigned avg);
        if (avg < 2) begin
            return '1;
        end
        return 32'((64'd1 << 32) / 64'(avg));
    endfunction

    function automatic recip_rom_t build_recip_rom();
        recip_rom_t rom;
        for (int unsigned i = 0; i < 256; i++) begin
            rom[i] = recip_of(i);
        end
        return rom;
    endfunction

endpackage

// File: rtl/delay_line.sv
// Generic synchronous-reset shift register; DELAY = 0 is a plain wire.
module delay_line
    #(
        parameter int unsigned DELAY = 6,
        parameter int unsigned WIDTH = 24
    )
    (
        input  logic             clk,
        input  logic             rst,
        input  logic [WIDTH-1:0] din,
        output logic [WIDTH-1:0] dout
    );

    generate
        if (DELAY == 0) begin : g_wire
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DELAY];
            logic [WIDTH-1:0] stage_d [DELAY];

            always_comb begin
                stage_d[0] = din;
                for (int unsigned i = 1; i < DELAY; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_q <= '{default: '0};
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign dout = stage_q[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/wb_recip_pack.sv
// White-balance output stage: registered per-channel reciprocals from a
// constant ROM, timing delay to match the multipliers, and HDMI bus packing.
module wb_recip_pack
    import hdmi_pkg::*;
    #(
        parameter int unsigned DELAY = 6
    )
    (
        input  logic              clk,
        input  logic              rst,
        input  logic [7:0]        avg_r,
        input  logic [7:0]        avg_g,
        input  logic [7:0]        avg_b,
        output logic [31:0]       recip_r,
        output logic [31:0]       recip_g,
        output logic [31:0]       recip_b,
        input  logic              i_hsync,
        input  logic              i_vsync,
        input  logic              i_de,
        input  logic [X_W-1:0]    i_x,
        input  logic [Y_W-1:0]    i_y,
        input  logic [7:0]        pix_r,
        input  logic [7:0]        pix_g,
        input  logic [7:0]        pix_b,
        output logic [PACK_W-1:0] o_pack
    );

    localparam recip_rom_t RECIP_ROM = build_recip_rom();

    logic [31:0] recip_r_d, recip_g_d, recip_b_d;
    logic [31:0] recip_r_q, recip_g_q, recip_b_q;

    always_comb begin
        recip_r_d = RECIP_ROM[avg_r];
        recip_g_d = RECIP_ROM[avg_g];
        recip_b_d = RECIP_ROM[avg_b];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            recip_r_q <= '0;
            recip_g_q <= '0;
            recip_b_q <= '0;
        end else begin
            recip_r_q <= recip_r_d;
            recip_g_q <= recip_g_d;
            recip_b_q <= recip_b_d;
        end
    end

    assign recip_r = recip_r_q;
    assign recip_g = recip_g_q;
    assign recip_b = recip_b_q;

    timing_t tim_in;
    timing_t tim_out;

    assign tim_in = '{hsync: i_hsync, vsync: i_vsync, de: i_de, x: i_x, y: i_y};

    delay_line #(
        .DELAY (DELAY),
        .WIDTH (TIM_W)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (tim_in),
        .dout (tim_out)
    );

    // The pixel clock itself rides on the top bit of the bus.
    always_comb begin
        o_pack                   = '0;
        o_pack[PK_CLK]           = clk;
        o_pack[PK_HSYNC]         = tim_out.hsync;
        o_pack[PK_VSYNC]         = tim_out.vsync;
        o_pack[PK_DE]            = tim_out.de;
        o_pack[PK_R_LSB +: 8]    = pix_r;
        o_pack[PK_G_LSB +: 8]    = pix_g;
        o_pack[PK_B_LSB +: 8]    = pix_b;
        o_pack[PK_X_LSB +: X_W]  = tim_out.x;
        o_pack[PK_Y_LSB +: Y_W]  = tim_out.y;
    end

endmodule

// File: tb/tb_wb_recip_pack.sv
// Self-checking bench for wb_recip_pack: cycle-indexed reference model plus
// directed vectors with literal expectations.
module tb_wb_recip_pack;

    localparam int unsigned DELAY = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  avg_r = '0, avg_g = '0, avg_b = '0;
    logic [31:0] recip_r, recip_g, recip_b;
    logic        i_hsync = 1'b0, i_vsync = 1'b0, i_de = 1'b0;
    logic [10:0] i_x = '0;
    logic [9:0]  i_y = '0;
    logic [7:0]  pix_r = '0, pix_g = '0, pix_b = '0;
    logic [48:0] o_pack;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    wb_recip_pack #(.DELAY(DELAY)) dut (
        .clk(clk), .rst(rst),
        .avg_r(avg_r), .avg_g(avg_g), .avg_b(avg_b),
        .recip_r(recip_r), .recip_g(recip_g), .recip_b(recip_b),
        .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de), .i_x(i_x), .i_y(i_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .o_pack(o_pack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_recip(input int unsigned a);
        if (a == 0 || a == 1) return 32'hFFFF_FFFF;
        return 32'((64'd1 << 32) / a);
    endfunction

    // Model: input word seen at each edge, last reset edge, expected outputs.
    logic [23:0] win [0:4095];
    int          cyc      = 0;
    int          last_rst = 0;
    logic [31:0] exp_r, exp_g, exp_b;
    logic [23:0] exp_tim;
    bit          model_ok = 0;

    always @(posedge clk) begin
        int src;
        cyc++;
        win[cyc] = {i_hsync, i_vsync, i_de, i_x, i_y};
        if (rst) last_rst = cyc;
        exp_r = rst ? 32'd0 : ref_recip(avg_r);
        exp_g = rst ? 32'd0 : ref_recip(avg_g);
        exp_b = rst ? 32'd0 : ref_recip(avg_b);
        src = cyc - int'(DELAY) + 1;
        exp_tim = (src < 1 || last_rst >= src) ? 24'd0 : win[src];
        model_ok = 1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("model_recip_r", 64'(recip_r), 64'(exp_r));
            check("model_recip_g", 64'(recip_g), 64'(exp_g));
            check("model_recip_b", 64'(recip_b), 64'(exp_b));
            check("model_pack", 64'(o_pack),
                  64'({1'b0, exp_tim[23:21], pix_r, pix_g, pix_b, exp_tim[20:0]}));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        check("reset_recip_r", 64'(recip_r), 64'd0);
        check("reset_de", 64'(o_pack[45]), 64'd0);
        rst = 1'b0;

        // Test 1
        avg_r = 8'd2; avg_g = 8'd3; avg_b = 8'd255;
        step();
        check("t1_recip_r", 64'(recip_r), 64'h8000_0000);
        check("t1_recip_g", 64'(recip_g), 64'h5555_5555);
        check("t1_recip_b", 64'(recip_b), 64'h0101_0101);

        // Test 2
        avg_r = 8'd0; avg_g = 8'd1; avg_b = 8'd128;
        step();
        check("t2_recip_r", 64'(recip_r), 64'hFFFF_FFFF);
        check("t2_recip_g", 64'(recip_g), 64'hFFFF_FFFF);
        check("t2_recip_b", 64'(recip_b), 64'h0200_0000);

        repeat (8) step();

        // Test 3: one-cycle de pulse emerges exactly DELAY cycles later
        i_de = 1'b1; i_x = 11'd5; i_y = 10'd7;
        step();
        i_de = 1'b0; i_x = '0; i_y = '0;
        check("t3_de_early", 64'(o_pack[45]), 64'd0);
        repeat (4) begin
            step();
            check("t3_de_early", 64'(o_pack[45]), 64'd0);
        end
        step();
        check("t3_de", 64'(o_pack[45]), 64'd1);
        check("t3_x", 64'(o_pack[20:10]), 64'd5);
        check("t3_y", 64'(o_pack[9:0]), 64'd7);
        step();
        check("t3_de_late", 64'(o_pack[45]), 64'd0);

        // Test 4: pixel bytes and delayed hsync in the same cycle
        i_hsync = 1'b1;
        step();
        i_hsync = 1'b0;
        repeat (5) step();
        pix_r = 8'hA5; pix_g = 8'h3C; pix_b = 8'hFF;
        #1;
        check("t4_rgb", 64'(o_pack[44:21]), 64'hA53CFF);
        check("t4_hsync", 64'(o_pack[47]), 64'd1);
        step();
        check("t4_hsync_gone", 64'(o_pack[47]), 64'd0);
        pix_r = '0; pix_g = '0; pix_b = '0;

        // Test 5: mid-line reset with de held high
        i_de = 1'b1;
        repeat (8) step();
        check("t5_de_before", 64'(o_pack[45]), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_recip_r", 64'(recip_r), 64'd0);
        check("t5_recip_b", 64'(recip_b), 64'd0);
        check("t5_de_rst", 64'(o_pack[45]), 64'd0);
        repeat (5) begin
            step();
            check("t5_de_hold", 64'(o_pack[45]), 64'd0);
        end
        step();
        check("t5_de_back", 64'(o_pack[45]), 64'd1);
        i_de = 1'b0;

        // Test 6: full average sweep against the model
        for (int a = 0; a < 256; a++) begin
            avg_r = 8'(a);
            avg_g = 8'(255 - a);
            avg_b = 8'(a) ^ 8'h5A;
            i_x = 11'(a * 3);
            i_y = 10'(a);
            i_vsync = a[0];
            step();
        end
        check("t6_recip_r_255", 64'(recip_r), 64'h0101_0101);
        check("t6_recip_g_0", 64'(recip_g), 64'hFFFF_FFFF);
        repeat (DELAY + 2) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
